// File: rtl/alu_operand_regfile.sv
// rtl/alu_operand_regfile.sv - ALU operand register file with FLAG/OVERFLOW status latches
module alu_operand_regfile #(
    parameter int W      = 8,
    parameter int A      = 3,
    parameter int BYPASS = 1
) (
    input  logic         CLK,
    input  logic         Reset,
    input  logic [A-1:0] RaddrA,
    input  logic [A-1:0] RaddrB,
    input  logic [A-1:0] Waddr,
    input  logic         WriteEn,
    input  logic [W-1:0] DataIn,
    input  logic         FlagWe,
    input  logic         FlagIn,
    input  logic         OvfWe,
    input  logic         OvfIn,
    output logic [W-1:0] DataOutA,
    output logic [W-1:0] DataOutB,
    output logic         FlagOut,
    output logic         OvfOut
);

    localparam int DEPTH = 1 << A;

    logic [W-1:0] r_mem [DEPTH];
    logic         r_flag;
    logic         r_ovf;
    logic         w_wr_live;
    logic         w_hit_a;
    logic         w_hit_b;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_flag <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            if (WriteEn) begin
                r_mem[Waddr] <= DataIn;
            end
            if (FlagWe) begin
                r_flag <= FlagIn;
            end
            if (OvfWe) begin
                r_ovf <= OvfIn;
            end
        end
    end

    // A write held off by reset must not leak onto the read ports either.
    assign w_wr_live = WriteEn && !Reset && (BYPASS != 0);
    assign w_hit_a   = w_wr_live && (RaddrA == Waddr);
    assign w_hit_b   = w_wr_live && (RaddrB == Waddr);

    always_comb begin
        DataOutA = r_mem[RaddrA];
        DataOutB = r_mem[RaddrB];
        if (w_hit_a) begin
            DataOutA = DataIn;
        end
        if (w_hit_b) begin
            DataOutB = DataIn;
        end
    end

    // Status bits come straight from the latches to keep the ALU flag loop registered.
    assign FlagOut = r_flag;
    assign OvfOut  = r_ovf;

endmodule
